// File: rtl/vslide_pkg.sv
// Shared types and helpers for the vslide beat issuer.
package vslide_pkg;

  // Element width encodings carried on cmd_sew / out_sew
  typedef enum logic [1:0] {
    SEW_E8  = 2'd0,
    SEW_E16 = 2'd1,
    SEW_E32 = 2'd2,
    SEW_E64 = 2'd3
  } sew_e;

  // One VRF beat is 64 bits wide
  localparam int BEAT_BYTES = 8;
  localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Byte enables for the final beat. A remainder of zero means that beat is full.
  function automatic logic [BEAT_BYTES-1:0] last_beat_be(input logic [BEAT_SHIFT-1:0] rem);
    logic [BEAT_BYTES-1:0] be;
    if (rem == '0) begin
      be = '1;
    end else begin
      be = (BEAT_BYTES'(1) << rem) - BEAT_BYTES'(1);
    end
    return be;
  endfunction

endpackage

// File: rtl/vslide_sb_delay.sv
// Fixed-depth delay line that carries beat sideband alongside the VRF read
// latency, so the sideband lines up with rd_data at the slide unit.
module vslide_sb_delay #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic [DEPTH-1:0] valid_q;
  logic [WIDTH-1:0] data_q [DEPTH];

  // Shift one stage per cycle; reset empties the line so no stale beat survives.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q[0] <= in_valid;
      data_q[0]  <= in_data;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        data_q[i]  <= data_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];

endmodule

// File: rtl/vslide_issue.sv
// Beat issuer for the slide unit. Takes one vslide1up/vslide1down command,
// reads the source group beat by beat in ascending order and presents each
// beat to the slide unit with aligned start/end/address/byte-enable sideband.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// ISSUE | one VRF read per cycle, beat index 0..beats-1
// DRAIN | reads done, waiting for the last beat to leave the delay line
// DONE  | zero-length command, one-cycle done pulse
module vslide_issue
  import vslide_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int VL_WIDTH   = 16,
  parameter int SEW_WIDTH  = 2,
  parameter int BE_WIDTH   = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_src_addr,
  input  logic [ADDR_WIDTH-1:0] cmd_dst_addr,
  input  logic [VL_WIDTH-1:0]   cmd_vl,
  input  logic [SEW_WIDTH-1:0]  cmd_sew,
  input  logic                  cmd_down,
  input  logic                  cmd_insert,
  input  logic [DATA_WIDTH-1:0] cmd_scalar,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_vec0,
  output logic [DATA_WIDTH-1:0] out_vec1,
  output logic [SEW_WIDTH-1:0]  out_sew,
  output logic                  out_opSel,
  output logic                  out_insert,
  output logic                  out_start,
  output logic                  out_end,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [BE_WIDTH-1:0]   out_be,
  output logic                  busy,
  output logic                  done
);

  // Byte count needs 3 extra bits so vl << 3 cannot overflow
  localparam int BYTES_WIDTH = VL_WIDTH + BEAT_SHIFT;
  localparam int SB_WIDTH    = 2 + ADDR_WIDTH + BE_WIDTH;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   src_q, dst_q;
  logic [VL_WIDTH-1:0]     beats_q, idx_q;
  logic [BE_WIDTH-1:0]     last_be_q;
  logic [DATA_WIDTH-1:0]   scalar_q;
  logic [SEW_WIDTH-1:0]    sew_q;
  logic                    down_q, insert_q;

  logic                    accept;
  logic [BYTES_WIDTH-1:0]  bytes_c;
  logic [VL_WIDTH-1:0]     beats_c;
  logic                    is_first, is_last;
  logic [SB_WIDTH-1:0]     sb_in, sb_out;
  logic                    sb_valid;
  logic [ADDR_WIDTH-1:0]   beat_dst;
  logic [BE_WIDTH-1:0]     beat_be;

  assign accept  = cmd_valid & cmd_ready;
  assign bytes_c = {{BEAT_SHIFT{1'b0}}, cmd_vl} << cmd_sew;
  // Round up to whole beats: full beats plus one if any bytes spill over
  assign beats_c = bytes_c[BYTES_WIDTH-1:BEAT_SHIFT]
                 + VL_WIDTH'(|bytes_c[BEAT_SHIFT-1:0]);

  // Next-state and handshake decode
  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    rd_en     = 1'b0;
    busy      = 1'b1;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          state_d = (beats_c == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        rd_en = 1'b1;
        if (is_last) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (sb_valid && out_end) begin
          state_d = IDLE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register plus command latch and beat index
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      beats_q   <= '0;
      idx_q     <= '0;
      last_be_q <= '0;
      scalar_q  <= '0;
      sew_q     <= '0;
      down_q    <= 1'b0;
      insert_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        src_q     <= cmd_src_addr;
        dst_q     <= cmd_dst_addr;
        beats_q   <= beats_c;
        idx_q     <= '0;
        last_be_q <= BE_WIDTH'(last_beat_be(bytes_c[BEAT_SHIFT-1:0]));
        scalar_q  <= cmd_scalar;
        sew_q     <= cmd_sew;
        down_q    <= cmd_down;
        insert_q  <= cmd_insert;
      end else if (rd_en) begin
        idx_q <= idx_q + VL_WIDTH'(1);
      end
    end
  end

  // Per-beat sideband; addresses wrap naturally at ADDR_WIDTH
  always_comb begin
    is_first = (idx_q == '0);
    is_last  = (state_q == ISSUE) && (idx_q == beats_q - VL_WIDTH'(1));
    beat_dst = dst_q + ADDR_WIDTH'(idx_q);
    beat_be  = is_last ? last_be_q : '1;
    rd_addr  = '0;
    sb_in    = '0;
    if (rd_en) begin
      rd_addr = src_q + ADDR_WIDTH'(idx_q);
      sb_in   = {is_first, is_last, beat_dst, beat_be};
    end
  end

  vslide_sb_delay #(
    .DEPTH (RD_LATENCY),
    .WIDTH (SB_WIDTH)
  ) u_sb_delay (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rd_en),
    .in_data   (sb_in),
    .out_valid (sb_valid),
    .out_data  (sb_out)
  );

  assign out_valid                             = sb_valid;
  assign {out_start, out_end, out_addr, out_be} = sb_out;
  // Gate the read data so the port idles at zero between beats and after reset
  assign out_vec0   = sb_valid ? rd_data : '0;
  assign out_vec1   = scalar_q;
  assign out_sew    = sew_q;
  assign out_opSel  = down_q;
  assign out_insert = insert_q;
  assign done       = (sb_valid & out_end) | (state_q == DONE);

endmodule

// File: tb/tb_vslide_issue.sv
// Directed bench for vslide_issue: one instance at read latency 1, one at 3,
// sharing the command inputs, each backed by its own VRF read model.
module tb_vslide_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic [31:0] cmd_src_addr, cmd_dst_addr;
  logic [15:0] cmd_vl;
  logic [1:0]  cmd_sew;
  logic        cmd_down, cmd_insert;
  logic [63:0] cmd_scalar;

  logic        d1_cmd_ready, d1_rd_en, d1_out_valid, d1_out_opsel, d1_out_insert;
  logic        d1_out_start, d1_out_end, d1_busy, d1_done;
  logic [31:0] d1_rd_addr, d1_out_addr;
  logic [63:0] d1_rd_data, d1_out_vec0, d1_out_vec1;
  logic [1:0]  d1_out_sew;
  logic [7:0]  d1_out_be;

  logic        d3_cmd_ready, d3_rd_en, d3_out_valid, d3_out_opsel, d3_out_insert;
  logic        d3_out_start, d3_out_end, d3_busy, d3_done;
  logic [31:0] d3_rd_addr, d3_out_addr;
  logic [63:0] d3_rd_data, d3_out_vec0, d3_out_vec1, p3_a, p3_b;
  logic [1:0]  d3_out_sew;
  logic [7:0]  d3_out_be;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  vslide_issue #(.RD_LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(d1_cmd_ready),
    .cmd_src_addr(cmd_src_addr), .cmd_dst_addr(cmd_dst_addr), .cmd_vl(cmd_vl),
    .cmd_sew(cmd_sew), .cmd_down(cmd_down), .cmd_insert(cmd_insert), .cmd_scalar(cmd_scalar),
    .rd_en(d1_rd_en), .rd_addr(d1_rd_addr), .rd_data(d1_rd_data),
    .out_valid(d1_out_valid), .out_vec0(d1_out_vec0), .out_vec1(d1_out_vec1),
    .out_sew(d1_out_sew), .out_opSel(d1_out_opsel), .out_insert(d1_out_insert),
    .out_start(d1_out_start), .out_end(d1_out_end), .out_addr(d1_out_addr),
    .out_be(d1_out_be), .busy(d1_busy), .done(d1_done)
  );

  vslide_issue #(.RD_LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(d3_cmd_ready),
    .cmd_src_addr(cmd_src_addr), .cmd_dst_addr(cmd_dst_addr), .cmd_vl(cmd_vl),
    .cmd_sew(cmd_sew), .cmd_down(cmd_down), .cmd_insert(cmd_insert), .cmd_scalar(cmd_scalar),
    .rd_en(d3_rd_en), .rd_addr(d3_rd_addr), .rd_data(d3_rd_data),
    .out_valid(d3_out_valid), .out_vec0(d3_out_vec0), .out_vec1(d3_out_vec1),
    .out_sew(d3_out_sew), .out_opSel(d3_out_opsel), .out_insert(d3_out_insert),
    .out_start(d3_out_start), .out_end(d3_out_end), .out_addr(d3_out_addr),
    .out_be(d3_out_be), .busy(d3_busy), .done(d3_done)
  );

  function automatic logic [63:0] vrf_word(input logic [31:0] a);
    return {a, a ^ 32'hA5A5_A5A5};
  endfunction

  // VRF read models: latency 1 and latency 3
  always @(posedge clk) begin
    d1_rd_data <= d1_rd_en ? vrf_word(d1_rd_addr) : 64'h0;
    p3_a       <= d3_rd_en ? vrf_word(d3_rd_addr) : 64'h0;
    p3_b       <= p3_a;
    d3_rd_data <= p3_b;
  end

  // Observed instance selector
  int          sel = 1;
  logic        s_rd_en, s_out_valid, s_start, s_end, s_opsel, s_ins, s_done, s_ready;
  logic [31:0] s_rd_addr, s_out_addr;
  logic [63:0] s_vec0, s_vec1;
  logic [1:0]  s_sew;
  logic [7:0]  s_be;
  assign s_rd_en     = (sel == 3) ? d3_rd_en      : d1_rd_en;
  assign s_rd_addr   = (sel == 3) ? d3_rd_addr    : d1_rd_addr;
  assign s_out_valid = (sel == 3) ? d3_out_valid  : d1_out_valid;
  assign s_start     = (sel == 3) ? d3_out_start  : d1_out_start;
  assign s_end       = (sel == 3) ? d3_out_end    : d1_out_end;
  assign s_opsel     = (sel == 3) ? d3_out_opsel  : d1_out_opsel;
  assign s_ins       = (sel == 3) ? d3_out_insert : d1_out_insert;
  assign s_done      = (sel == 3) ? d3_done       : d1_done;
  assign s_ready     = (sel == 3) ? d3_cmd_ready  : d1_cmd_ready;
  assign s_out_addr  = (sel == 3) ? d3_out_addr   : d1_out_addr;
  assign s_vec0      = (sel == 3) ? d3_out_vec0   : d1_out_vec0;
  assign s_vec1      = (sel == 3) ? d3_out_vec1   : d1_out_vec1;
  assign s_sew       = (sel == 3) ? d3_out_sew    : d1_out_sew;
  assign s_be        = (sel == 3) ? d3_out_be     : d1_out_be;

  int          rd_cyc[$], ob_cyc[$], done_cyc[$], acc_cyc[$];
  logic [31:0] rd_adr[$], ob_addr[$];
  logic [7:0]  ob_be[$];
  logic        ob_start[$], ob_end[$], ob_opsel[$], ob_ins[$], ready_at_done[$];
  logic [63:0] ob_vec0[$], ob_vec1[$];
  logic [1:0]  ob_sew[$];
  logic        ready_after;
  bit          timed_out;

  // Record activity per cycle (cycle 0 = first negedge after accept) until
  // n_done done pulses plus one cycle; a held cmd_valid is dropped right after
  // the accepting edge.
  task automatic collect(input int which, input int n_done, input int max_cycles);
    bit stop_next = 0;
    rd_cyc.delete(); ob_cyc.delete(); done_cyc.delete(); acc_cyc.delete();
    rd_adr.delete(); ob_addr.delete(); ob_be.delete(); ob_start.delete();
    ob_end.delete(); ob_opsel.delete(); ob_ins.delete(); ready_at_done.delete();
    ob_vec0.delete(); ob_vec1.delete(); ob_sew.delete();
    sel = which;
    timed_out = 0;
    ready_after = 1'b0;
    for (int c = 0; c < max_cycles; c++) begin
      @(negedge clk);
      if (stop_next) begin
        ready_after = s_ready;
        return;
      end
      if (s_rd_en) begin
        rd_cyc.push_back(c);
        rd_adr.push_back(s_rd_addr);
      end
      if (s_out_valid) begin
        ob_cyc.push_back(c);   ob_addr.push_back(s_out_addr); ob_be.push_back(s_be);
        ob_start.push_back(s_start); ob_end.push_back(s_end);
        ob_vec0.push_back(s_vec0);   ob_vec1.push_back(s_vec1);
        ob_opsel.push_back(s_opsel); ob_ins.push_back(s_ins); ob_sew.push_back(s_sew);
      end
      if (s_done) begin
        done_cyc.push_back(c);
        ready_at_done.push_back(s_ready);
        if (done_cyc.size() == n_done) stop_next = 1;
      end
      if (cmd_valid && s_ready) begin
        acc_cyc.push_back(c);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
      end
    end
    timed_out = 1;
  endtask

  task automatic issue(input logic [31:0] src, input logic [31:0] dst, input logic [15:0] vl,
                       input logic [1:0] sew, input logic down, input logic ins,
                       input logic [63:0] scalar, input bit hold);
    cmd_src_addr = src; cmd_dst_addr = dst; cmd_vl = vl; cmd_sew = sew;
    cmd_down = down; cmd_insert = ins; cmd_scalar = scalar;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!d1_busy && !d3_busy) return;
    end
    tests++; fails++;
    $display("FAIL wait_idle: busy d1=%0b d3=%0b, required both 0", d1_busy, d3_busy);
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_src_addr = '0; cmd_dst_addr = '0; cmd_vl = '0;
    cmd_sew = '0; cmd_down = 1'b0; cmd_insert = 1'b0; cmd_scalar = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    tests++;
    if ({d1_cmd_ready, d1_busy, d1_out_valid, d1_done, d1_rd_en} !== 5'b10000) begin
      fails++;
      $display("FAIL reset_ctl_d1: ready/busy/valid/done/rd_en=%b, required 10000",
               {d1_cmd_ready, d1_busy, d1_out_valid, d1_done, d1_rd_en});
    end
    tests++;
    if ({d3_cmd_ready, d3_busy, d3_out_valid, d3_done, d3_rd_en} !== 5'b10000) begin
      fails++;
      $display("FAIL reset_ctl_d3: ready/busy/valid/done/rd_en=%b, required 10000",
               {d3_cmd_ready, d3_busy, d3_out_valid, d3_done, d3_rd_en});
    end
    tests++;
    if (d1_out_addr !== 32'h0 || d1_out_be !== 8'h0 || d1_out_vec1 !== 64'h0 || d1_rd_addr !== 32'h0) begin
      fails++;
      $display("FAIL reset_data: out_addr=%h out_be=%h vec1=%h rd_addr=%h, required all 0",
               d1_out_addr, d1_out_be, d1_out_vec1, d1_rd_addr);
    end
  endtask

  task automatic test_basic_up();
    logic [7:0] e_be [3] = '{8'hFF, 8'hFF, 8'h0F};
    issue(32'h10, 32'h40, 16'd20, 2'd0, 1'b0, 1'b0, 64'h1234, 0);
    collect(1, 1, 30);
    tests++;
    if (timed_out) begin fails++; $display("FAIL basic_timeout: no done within 30 cycles, required done"); end
    tests++;
    if (rd_adr.size() != 3 || ob_addr.size() != 3) begin
      fails++;
      $display("FAIL basic_counts: reads=%0d beats=%0d, required 3 and 3", rd_adr.size(), ob_addr.size());
    end
    for (int i = 0; i < 3 && i < rd_adr.size() && i < ob_addr.size(); i++) begin
      tests++;
      if (rd_adr[i] !== 32'h10 + i || rd_cyc[i] != i) begin
        fails++;
        $display("FAIL basic_rd%0d: addr=%h cyc=%0d, required %h cyc %0d", i, rd_adr[i], rd_cyc[i], 32'h10 + i, i);
      end
      tests++;
      if (ob_addr[i] !== 32'h40 + i || ob_be[i] !== e_be[i] || ob_start[i] !== (i == 0) ||
          ob_end[i] !== (i == 2) || ob_vec0[i] !== vrf_word(32'h10 + i) || ob_cyc[i] != i + 1) begin
        fails++;
        $display("FAIL basic_beat%0d: addr=%h be=%h s=%b e=%b vec0=%h cyc=%0d, required addr=%h be=%h s=%b e=%b vec0=%h cyc=%0d",
                 i, ob_addr[i], ob_be[i], ob_start[i], ob_end[i], ob_vec0[i], ob_cyc[i],
                 32'h40 + i, e_be[i], (i == 0), (i == 2), vrf_word(32'h10 + i), i + 1);
      end
    end
    tests++;
    if (done_cyc.size() != 1 || done_cyc[0] != 3 || ready_at_done[0] !== 1'b0 || ready_after !== 1'b1) begin
      fails++;
      $display("FAIL basic_done: done_cyc=%0d ready_at_done=%b ready_after=%b, required 3 0 1",
               done_cyc[0], ready_at_done[0], ready_after);
    end
    wait_idle();
  endtask

  task automatic test_single_down();
    issue(32'h33, 32'h77, 16'd1, 2'd3, 1'b1, 1'b0, 64'hA5, 0);
    collect(1, 1, 20);
    tests++;
    if (timed_out || ob_addr.size() != 1 || rd_adr.size() != 1) begin
      fails++;
      $display("FAIL single_counts: timeout=%0b reads=%0d beats=%0d, required 0 1 1",
               timed_out, rd_adr.size(), ob_addr.size());
    end
    tests++;
    if (ob_start[0] !== 1'b1 || ob_end[0] !== 1'b1 || ob_be[0] !== 8'hFF || ob_addr[0] !== 32'h77 ||
        rd_adr[0] !== 32'h33) begin
      fails++;
      $display("FAIL single_sideband: s=%b e=%b be=%h addr=%h rd=%h, required 1 1 ff 77 33",
               ob_start[0], ob_end[0], ob_be[0], ob_addr[0], rd_adr[0]);
    end
    tests++;
    if (ob_vec1[0] !== 64'hA5 || ob_opsel[0] !== 1'b1 || ob_sew[0] !== 2'd3 || ob_ins[0] !== 1'b0) begin
      fails++;
      $display("FAIL single_fields: vec1=%h opSel=%b sew=%0d ins=%b, required a5 1 3 0",
               ob_vec1[0], ob_opsel[0], ob_sew[0], ob_ins[0]);
    end
    tests++;
    if (done_cyc[0] != 1 || ready_after !== 1'b1) begin
      fails++;
      $display("FAIL single_done: done_cyc=%0d ready_after=%b, required 1 1", done_cyc[0], ready_after);
    end
    wait_idle();
  endtask

  task automatic test_vl_zero();
    issue(32'h5, 32'h6, 16'd0, 2'd2, 1'b0, 1'b0, 64'h0, 0);
    collect(1, 1, 10);
    tests++;
    if (timed_out || rd_adr.size() != 0 || ob_addr.size() != 0) begin
      fails++;
      $display("FAIL vl0_activity: timeout=%0b reads=%0d beats=%0d, required 0 0 0",
               timed_out, rd_adr.size(), ob_addr.size());
    end
    tests++;
    if (done_cyc[0] != 0 || ready_at_done[0] !== 1'b0 || ready_after !== 1'b1) begin
      fails++;
      $display("FAIL vl0_done: done_cyc=%0d ready_at_done=%b ready_after=%b, required 0 0 1",
               done_cyc[0], ready_at_done[0], ready_after);
    end
    wait_idle();
  endtask

  task automatic test_partial_insert();
    issue(32'h200, 32'h7, 16'd3, 2'd1, 1'b0, 1'b1, 64'hBEEF, 0);
    collect(1, 1, 20);
    tests++;
    if (timed_out || ob_addr.size() != 1 || ob_be[0] !== 8'h3F || ob_ins[0] !== 1'b1 ||
        ob_addr[0] !== 32'h7 || ob_vec0[0] !== vrf_word(32'h200)) begin
      fails++;
      $display("FAIL partial_beat: beats=%0d be=%h ins=%b addr=%h vec0=%h, required 1 3f 1 7 %h",
               ob_addr.size(), ob_be[0], ob_ins[0], ob_addr[0], ob_vec0[0], vrf_word(32'h200));
    end
    wait_idle();
  endtask

  task automatic test_wrap();
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFE, 16'd16, 2'd0, 1'b0, 1'b0, 64'h0, 0);
    collect(1, 1, 20);
    tests++;
    if (timed_out || rd_adr.size() != 2 || rd_adr[0] !== 32'hFFFF_FFFF || rd_adr[1] !== 32'h0) begin
      fails++;
      $display("FAIL wrap_rd: reads=%0d a0=%h a1=%h, required 2 ffffffff 00000000",
               rd_adr.size(), rd_adr[0], rd_adr[1]);
    end
    tests++;
    if (ob_addr.size() != 2 || ob_addr[0] !== 32'hFFFF_FFFE || ob_addr[1] !== 32'hFFFF_FFFF ||
        ob_be[1] !== 8'hFF || ob_vec0[1] !== vrf_word(32'h0)) begin
      fails++;
      $display("FAIL wrap_out: beats=%0d a0=%h a1=%h be1=%h, required 2 fffffffe ffffffff ff",
               ob_addr.size(), ob_addr[0], ob_addr[1], ob_be[1]);
    end
    wait_idle();
  endtask

  task automatic test_back_to_back();
    logic [31:0] e_rd  [4] = '{32'h100, 32'h101, 32'h300, 32'h301};
    logic [31:0] e_out [4] = '{32'h200, 32'h201, 32'h400, 32'h401};
    int          e_rc  [4] = '{0, 1, 4, 5};
    int          e_oc  [4] = '{1, 2, 5, 6};
    issue(32'h100, 32'h200, 16'd16, 2'd0, 1'b0, 1'b0, 64'h0, 1);
    cmd_src_addr = 32'h300; cmd_dst_addr = 32'h400; cmd_vl = 16'd8; cmd_sew = 2'd1;
    collect(1, 2, 40);
    tests++;
    if (timed_out || rd_adr.size() != 4 || ob_addr.size() != 4) begin
      fails++;
      $display("FAIL b2b_counts: timeout=%0b reads=%0d beats=%0d, required 0 4 4",
               timed_out, rd_adr.size(), ob_addr.size());
    end
    tests++;
    if (acc_cyc.size() != 1 || acc_cyc[0] != 3 || done_cyc[0] != 2 || done_cyc[1] != 6) begin
      fails++;
      $display("FAIL b2b_timing: accept2=%0d done0=%0d done1=%0d, required 3 2 6",
               acc_cyc[0], done_cyc[0], done_cyc[1]);
    end
    for (int i = 0; i < 4 && i < rd_adr.size() && i < ob_addr.size(); i++) begin
      tests++;
      if (rd_adr[i] !== e_rd[i] || rd_cyc[i] != e_rc[i] || ob_addr[i] !== e_out[i] ||
          ob_cyc[i] != e_oc[i] || ob_start[i] !== (i % 2 == 0) || ob_end[i] !== (i % 2 == 1)) begin
        fails++;
        $display("FAIL b2b_beat%0d: rd=%h@%0d out=%h@%0d s=%b e=%b, required rd=%h@%0d out=%h@%0d s=%b e=%b",
                 i, rd_adr[i], rd_cyc[i], ob_addr[i], ob_cyc[i], ob_start[i], ob_end[i],
                 e_rd[i], e_rc[i], e_out[i], e_oc[i], (i % 2 == 0), (i % 2 == 1));
      end
    end
    wait_idle();
  endtask

  task automatic test_latency3();
    logic [7:0] e_be [3] = '{8'hFF, 8'hFF, 8'h0F};
    issue(32'h20, 32'h80, 16'd5, 2'd2, 1'b0, 1'b0, 64'h0, 0);
    collect(3, 1, 30);
    tests++;
    if (timed_out || rd_adr.size() != 3 || ob_addr.size() != 3) begin
      fails++;
      $display("FAIL lat3_counts: timeout=%0b reads=%0d beats=%0d, required 0 3 3",
               timed_out, rd_adr.size(), ob_addr.size());
    end
    for (int i = 0; i < 3 && i < rd_adr.size() && i < ob_addr.size(); i++) begin
      tests++;
      if (ob_cyc[i] - rd_cyc[i] != 3 || rd_cyc[i] != i || ob_be[i] !== e_be[i] ||
          ob_addr[i] !== 32'h80 + i || ob_vec0[i] !== vrf_word(32'h20 + i) || ob_end[i] !== (i == 2)) begin
        fails++;
        $display("FAIL lat3_beat%0d: rd@%0d out@%0d be=%h addr=%h vec0=%h e=%b, required rd@%0d out@%0d be=%h addr=%h vec0=%h e=%b",
                 i, rd_cyc[i], ob_cyc[i], ob_be[i], ob_addr[i], ob_vec0[i], ob_end[i],
                 i, i + 3, e_be[i], 32'h80 + i, vrf_word(32'h20 + i), (i == 2));
      end
    end
    tests++;
    if (done_cyc[0] != 5 || ready_after !== 1'b1) begin
      fails++;
      $display("FAIL lat3_done: done_cyc=%0d ready_after=%b, required 5 1", done_cyc[0], ready_after);
    end
    wait_idle();
  endtask

  task automatic test_reset_mid();
    int stray = 0;
    issue(32'h50, 32'h90, 16'd32, 2'd0, 1'b0, 1'b0, 64'h0, 0);
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (d1_rd_en !== 1'b1 || d1_rd_addr !== 32'h51) begin
      fails++;
      $display("FAIL rstmid_pre: rd_en=%b rd_addr=%h, required 1 51", d1_rd_en, d1_rd_addr);
    end
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if ({d1_out_valid, d1_busy, d1_cmd_ready, d1_rd_en, d1_done} !== 5'b00100 ||
        {d3_out_valid, d3_busy, d3_cmd_ready, d3_rd_en, d3_done} !== 5'b00100) begin
      fails++;
      $display("FAIL rstmid_state: d1 valid/busy/ready/rd/done=%b d3=%b, required 00100 00100",
               {d1_out_valid, d1_busy, d1_cmd_ready, d1_rd_en, d1_done},
               {d3_out_valid, d3_busy, d3_cmd_ready, d3_rd_en, d3_done});
    end
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (d1_out_valid || d3_out_valid || d1_rd_en || d3_rd_en || d1_done || d3_done) stray++;
    end
    tests++;
    if (stray != 0) begin
      fails++;
      $display("FAIL rstmid_stale: %0d cycles with activity after reset, required 0", stray);
    end
  endtask

  initial begin
    test_reset();
    test_basic_up();
    test_single_down();
    test_vl_zero();
    test_partial_insert();
    test_wrap();
    test_back_to_back();
    test_latency3();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
